// File: rtl/spi_adc_pkg.sv
// Shared definitions for the multi-channel SPI ADC front end:
// FSM state encoding and the default PmodMIC3 frame layout.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_e;

  localparam int unsigned PMOD_FRAME_BITS = 16;
  localparam int unsigned PMOD_LEAD_BITS  = 3;
  localparam int unsigned PMOD_DATA_W     = 12;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: idle-high sck, CLK_DIV clk cycles per half-period,
// with single-cycle strobes on the clk edge where sck falls or rises.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic active_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick = (cnt_q == CNT_LAST);

  // load_i drops sck for the first bit; afterwards sck toggles every CLK_DIV cycles
  always_comb begin
    cnt_d = '0;
    sck_d = 1'b1;
    if (load_i) begin
      sck_d = 1'b0;
    end else if (active_i) begin
      if (tick) begin
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sck_d = sck_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = active_i & ~sck_q & tick;
  assign fall_o = load_i | (active_i & sck_q & tick);

endmodule

// File: rtl/spi_adc.sv
// Periodic SPI reader for NCH ADCs sharing sck/ss, with a valid/ready
// output register and a sticky overrun flag.
module spi_adc_multi
  import spi_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 5,
  parameter int unsigned NCH        = 2,
  parameter int unsigned DATA_W     = PMOD_DATA_W,
  parameter int unsigned FRAME_BITS = PMOD_FRAME_BITS,
  parameter int unsigned LEAD_BITS  = PMOD_LEAD_BITS,
  parameter int unsigned SAMPLE_DIV = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  sck,
  output logic                  ss,
  input  logic [NCH-1:0]        miso,
  output logic [NCH*DATA_W-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun
);

  if (CLK_DIV < 1 || NCH < 1 || DATA_W < 1) begin : g_bad_param
    $error("spi_adc_multi: CLK_DIV, NCH and DATA_W must be >= 1");
  end
  if (LEAD_BITS + DATA_W > FRAME_BITS) begin : g_bad_frame
    $error("spi_adc_multi: LEAD_BITS + DATA_W exceeds FRAME_BITS");
  end
  if (SAMPLE_DIV < 2 * CLK_DIV * (FRAME_BITS + 2) + 2) begin : g_bad_rate
    $error("spi_adc_multi: SAMPLE_DIV too small for one frame");
  end

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] CAP_LO   = BW'(LEAD_BITS);
  localparam logic [BW-1:0] CAP_HI   = BW'(LEAD_BITS + DATA_W);
  localparam logic [BW-1:0] BIT_END  = BW'(FRAME_BITS);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_DIV - 1);

  state_e                  state_q, state_d;
  logic [PW-1:0]           ph_q, ph_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    win_q, win_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [NCH*DATA_W-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;
  logic [NCH*DATA_W-1:0]   sr_all;
  logic                    sck_load, rise, fall, cap, load, xfer;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (sck_load),
    .active_i(state_q == S_SHIFT),
    .sck_o   (sck),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // bit_q counts falling edges; the capture window for bit k is latched at
  // its falling edge so the rising edge only needs win_q
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    win_d    = win_q;
    sck_load = 1'b0;
    if (fall) begin
      bit_d = bit_q + 1'b1;
      win_d = (bit_q >= CAP_LO) && (bit_q < CAP_HI);
    end
    case (state_q)
      S_IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        win_d = 1'b0;
        if (en && tmr_q == '0) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (ph_q == PH_LAST) begin
          ph_d     = '0;
          sck_load = 1'b1;
          state_d  = S_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (rise && bit_q == BIT_END) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = S_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cap  = rise & win_q;
  assign load = (state_q == S_HOLD) && (ph_q == PH_LAST);
  assign xfer = valid_q & data_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DATA_W-1:0] sr_q;
    always_ff @(posedge clk) begin
      if (rst)      sr_q <= '0;
      else if (cap) sr_q <= DATA_W'({sr_q, miso[i]});
    end
    assign sr_all[i*DATA_W +: DATA_W] = sr_q;
  end

  // a load coinciding with a transfer leaves overrun untouched
  always_comb begin
    tmr_d   = en ? ((tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1) : '0;
    data_d  = load ? sr_all : data_q;
    valid_d = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
    ovr_d   = ovr_q;
    if (load && valid_q && !xfer) ovr_d = 1'b1;
    else if (xfer && !load)       ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      win_q   <= 1'b0;
      tmr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ss         = (state_q == S_IDLE);
  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule
